// File: rtl/frame_pattern_gen_pkg.sv
// Shared types and constants for the frame pattern generator: payload mode
// encodings, default sync word and FSM state encoding.
package frame_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } fpg_state_e;

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_FILL = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

  localparam logic [31:0] DEF_SYNC_WORD = 32'h1ACFFC1D;
  localparam logic [31:0] DEF_FILL_WORD = 32'h000000A5;

  // One-position left rotate of a 32-bit vector; callers truncate to their width.
  function automatic logic [31:0] rotl1_32(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(w)) begin
        r[(i + 1) % int'(w)] = v[i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_pattern_gen_prbs31_step.sv
// Combinational N-step advance of the PRBS31 (x^31 + x^28 + 1) shift register.
// bits_out holds the N generated bits, oldest in the MSB, newest in bit 0.
module prbs31_step #(
  parameter int N = 8
) (
  input  logic [30:0]  state_in,
  output logic [30:0]  state_out,
  output logic [N-1:0] bits_out
);

  logic [30:0]  lfsr_s;
  logic [N-1:0] bits_s;

  // Unrolled shifts; each new bit is the XOR of the taps 31 and 28 steps back.
  always_comb begin
    lfsr_s = state_in;
    bits_s = '0;
    for (int k = 0; k < N; k++) begin
      bits_s[N-1-k] = lfsr_s[30] ^ lfsr_s[27];
      lfsr_s        = {lfsr_s[29:0], lfsr_s[30] ^ lfsr_s[27]};
    end
  end

  assign state_out = lfsr_s;
  assign bits_out  = bits_s;

endmodule

// File: rtl/frame_pattern_gen.sv
// Test-frame generator: sync word + frame counter header followed by a
// selectable payload, throttled by the downstream FIFO fill level.
module frame_pattern_gen
  import frame_pattern_gen_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          FRAME_LEN = 1024,
  parameter int          FIFO_AW   = 15,
  parameter int          FIFO_WM   = 16000,
  parameter logic [31:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter logic [31:0] FILL_WORD = DEF_FILL_WORD,
  parameter logic [30:0] PRBS_SEED = 31'h1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [31:0]        frame_limit,
  input  logic [FIFO_AW-1:0] wrusedw,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_en,
  output logic               sof,
  output logic               eof,
  output logic               busy,
  output logic               done,
  output logic [31:0]        frame_cnt
);

  localparam int                 HDR_WORDS = 64 / DATA_W;
  localparam int                 POS_W     = $clog2(FRAME_LEN);
  localparam logic [POS_W-1:0]   POS_HDR_LAST = POS_W'(HDR_WORDS - 1);
  localparam logic [POS_W-1:0]   POS_LAST     = POS_W'(FRAME_LEN - 1);
  localparam logic [FIFO_AW-1:0] WM_LVL       = FIFO_AW'(FIFO_WM);

  fpg_state_e          state_r;
  fpg_state_e          state_nx_s;
  logic                ready_q_r;
  logic [POS_W-1:0]    pos_r;
  logic [31:0]         frame_cnt_r;
  logic [31:0]         limit_r;
  logic [1:0]          mode_r;
  logic                stop_pend_r;
  logic                busy_r;
  logic [30:0]         prbs_r;
  logic [DATA_W-1:0]   walk_r;
  logic [DATA_W-1:0]   data_out_r;
  logic                data_en_r;
  logic                sof_r;
  logic                eof_r;
  logic                done_r;

  logic                issue_s;
  logic                start_acc_s;
  logic                hdr_last_s;
  logic                frame_last_s;
  logic                finish_s;
  logic [31:0]         cnt_inc_s;
  logic [63:0]         hdr_s;
  logic [6:0]          hdr_shift_s;
  logic [DATA_W-1:0]   hdr_word_s;
  logic [DATA_W-1:0]   word_s;
  logic [30:0]         prbs_nx_s;
  logic [DATA_W-1:0]   prbs_bits_s;

  prbs31_step #(
    .N(DATA_W)
  ) u_prbs (
    .state_in (prbs_r),
    .state_out(prbs_nx_s),
    .bits_out (prbs_bits_s)
  );

  assign issue_s      = ready_q_r && (state_r != ST_IDLE);
  assign hdr_last_s   = (pos_r == POS_HDR_LAST);
  assign frame_last_s = (state_r == ST_PAYLOAD) && (pos_r == POS_LAST);
  assign cnt_inc_s    = frame_cnt_r + 32'd1;
  // A stop arriving on the very last word still ends the run at this frame.
  assign finish_s     = stop_pend_r || stop || ((limit_r != 32'd0) && (cnt_inc_s == limit_r));
  assign hdr_s        = {SYNC_WORD, frame_cnt_r};

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; start is only honoured once the previous run has fully drained.
  always_comb begin
    state_nx_s  = state_r;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !busy_r) begin
          state_nx_s  = ST_HDR;
          start_acc_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (issue_s && hdr_last_s) begin
          state_nx_s = ST_PAYLOAD;
        end else begin
          state_nx_s = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (issue_s && frame_last_s) begin
          state_nx_s = finish_s ? ST_IDLE : ST_HDR;
        end else begin
          state_nx_s = ST_PAYLOAD;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Word selection: header slices MSB-first, otherwise the latched payload mode.
  always_comb begin
    word_s      = '0;
    hdr_shift_s = 7'(DATA_W) * (7'(HDR_WORDS - 1) - 7'(pos_r));
    hdr_word_s  = DATA_W'(hdr_s >> hdr_shift_s);
    case (state_r)
      ST_HDR: begin
        word_s = hdr_word_s;
      end
      ST_PAYLOAD: begin
        case (mode_r)
          MODE_RAMP: word_s = DATA_W'(pos_r);
          MODE_PRBS: word_s = prbs_bits_s;
          MODE_FILL: word_s = FILL_WORD[DATA_W-1:0];
          MODE_WALK: word_s = walk_r;
          default:   word_s = '0;
        endcase
      end
      default: begin
        word_s = '0;
      end
    endcase
  end

  // FIFO readiness sample and run parameters latched at start.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ready_q_r <= 1'b0;
      mode_r    <= MODE_RAMP;
      limit_r   <= 32'd0;
    end else begin
      ready_q_r <= (wrusedw < WM_LVL);
      if (start_acc_s) begin
        mode_r  <= mode;
        limit_r <= frame_limit;
      end else begin
        mode_r  <= mode_r;
        limit_r <= limit_r;
      end
    end
  end

  // Frame position, frame counter, PRBS and walking-one state; all hold when nothing issues.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pos_r       <= '0;
      frame_cnt_r <= 32'd0;
      prbs_r      <= PRBS_SEED;
      walk_r      <= DATA_W'(1);
    end else if (start_acc_s) begin
      pos_r       <= '0;
      frame_cnt_r <= 32'd0;
      prbs_r      <= PRBS_SEED;
      walk_r      <= DATA_W'(1);
    end else if (issue_s) begin
      pos_r <= frame_last_s ? '0 : pos_r + POS_W'(1);
      if (frame_last_s) begin
        frame_cnt_r <= cnt_inc_s;
      end
      if ((state_r == ST_PAYLOAD) && (mode_r == MODE_PRBS)) begin
        prbs_r <= prbs_nx_s;
      end
      walk_r <= (state_r == ST_PAYLOAD) ? DATA_W'(rotl1_32(32'(walk_r), DATA_W)) : DATA_W'(1);
    end
  end

  // Stop request and run-in-progress flags.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stop_pend_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (state_r == ST_IDLE) begin
        stop_pend_r <= 1'b0;
      end else if (stop) begin
        stop_pend_r <= 1'b1;
      end
      if (start_acc_s) begin
        busy_r <= 1'b1;
      end else if (done_r) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Output register: one cycle behind the issue decision.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      data_out_r <= '0;
      data_en_r  <= 1'b0;
      sof_r      <= 1'b0;
      eof_r      <= 1'b0;
      done_r     <= 1'b0;
    end else if (issue_s) begin
      data_out_r <= word_s;
      data_en_r  <= 1'b1;
      sof_r      <= (state_r == ST_HDR) && (pos_r == '0);
      eof_r      <= frame_last_s;
      done_r     <= frame_last_s && finish_s;
    end else begin
      data_out_r <= '0;
      data_en_r  <= 1'b0;
      sof_r      <= 1'b0;
      eof_r      <= 1'b0;
      done_r     <= 1'b0;
    end
  end

  assign data_out  = data_out_r;
  assign data_en   = data_en_r;
  assign sof       = sof_r;
  assign eof       = eof_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Bench for frame_pattern_gen: three instances (8/16/32-bit words) driven by
// shared controls, checked against a stream model and a cycle-exact vector table.
module tb_frame_pattern_gen;

  logic        clk = 1'b0;
  logic        RST;
  logic        start, stop;
  logic [1:0]  mode;
  logic [31:0] frame_limit;
  logic [14:0] wrusedw;

  logic [7:0]  d8;  logic en8,  sof8,  eof8,  busy8,  done8;  logic [31:0] fc8;
  logic [15:0] d16; logic en16, sof16, eof16, busy16, done16; logic [31:0] fc16;
  logic [31:0] d32; logic en32, sof32, eof32, busy32, done32; logic [31:0] fc32;

  localparam int FL8 = 16, FL16 = 24, FL32 = 8;

  always #5 clk = ~clk;

  frame_pattern_gen #(.DATA_W(8), .FRAME_LEN(FL8)) u_dut8 (
    .clk(clk), .RST(RST), .start(start), .stop(stop), .mode(mode), .frame_limit(frame_limit),
    .wrusedw(wrusedw), .data_out(d8), .data_en(en8), .sof(sof8), .eof(eof8), .busy(busy8),
    .done(done8), .frame_cnt(fc8));

  frame_pattern_gen #(.DATA_W(16), .FRAME_LEN(FL16)) u_dut16 (
    .clk(clk), .RST(RST), .start(start), .stop(stop), .mode(mode), .frame_limit(frame_limit),
    .wrusedw(wrusedw), .data_out(d16), .data_en(en16), .sof(sof16), .eof(eof16), .busy(busy16),
    .done(done16), .frame_cnt(fc16));

  frame_pattern_gen #(.DATA_W(32), .FRAME_LEN(FL32)) u_dut32 (
    .clk(clk), .RST(RST), .start(start), .stop(stop), .mode(mode), .frame_limit(frame_limit),
    .wrusedw(wrusedw), .data_out(d32), .data_en(en32), .sof(sof32), .eof(eof32), .busy(busy32),
    .done(done32), .frame_cnt(fc32));

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic        done;
  } word_t;

  typedef struct packed {
    logic [14:0] wr;
    logic [7:0]  data;
    logic        en;
    logic        sof;
    logic        eof;
    logic        done;
    logic        busy;
  } vec_t;

  word_t cap[3][$];
  int    stray[3];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    gaps8;

  // Capture every emitted word of each instance.
  always @(negedge clk) begin
    if (en8) cap[0].push_back('{data: 32'(d8), sof: sof8, eof: eof8, done: done8});
    else if (done8) stray[0]++;
    if (en16) cap[1].push_back('{data: 32'(d16), sof: sof16, eof: eof16, done: done16});
    else if (done16) stray[1]++;
    if (en32) cap[2].push_back('{data: d32, sof: sof32, eof: eof32, done: done32});
    else if (done32) stray[2]++;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [14:0] rand_fill();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 15'd15999;
      1:       return 15'd16000;
      2, 3:    return 15'($urandom_range(16001, 32767));
      default: return 15'($urandom_range(0, 15998));
    endcase
  endfunction

  // Expected stream: header = sync then frame number, payload by mode; PRBS bits
  // come from the recurrence x[n] = x[n-31] ^ x[n-28] seeded with x[-1]=1.
  task automatic compare_stream(input int idx, input int dw, input int fl, input int md,
                                input int nfr, input string nm);
    int          hdr, i, n;
    logic [63:0] hw;
    logic [31:0] mask, ed, fw;
    logic [30:0] seed;
    bit          pb[$];
    bit          nb;
    word_t       g;
    hdr  = 64 / dw;
    mask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    seed = 31'h1;
    for (int b = 30; b >= 0; b--) pb.push_back(seed[b]);
    check({nm, " length"}, 64'(cap[idx].size()), 64'(fl * nfr));
    check({nm, " stray done"}, 64'(stray[idx]), 64'd0);
    for (int f = 0; f < nfr; f++) begin
      fw = f[31:0];
      hw = {32'h1ACFFC1D, fw};
      for (int w = 0; w < fl; w++) begin
        if (w < hdr) begin
          ed = 32'(hw >> (64 - (w + 1) * dw)) & mask;
        end else begin
          case (md)
            0: ed = 32'(w) & mask;
            1: begin
              ed = 32'd0;
              for (int b = 0; b < dw; b++) begin
                n  = pb.size();
                nb = pb[n - 31] ^ pb[n - 28];
                pb.push_back(nb);
                ed = (ed << 1) | 32'(nb);
              end
              while (pb.size() > 64) void'(pb.pop_front());
            end
            2: ed = 32'hA5 & mask;
            default: ed = 32'd1 << ((w - hdr) % dw);
          endcase
        end
        i = f * fl + w;
        if (i < cap[idx].size()) begin
          g = cap[idx][i];
          check($sformatf("%s f%0d w%0d", nm, f, w), 64'({g.data, g.sof, g.eof, g.done}),
                64'({ed, w == 0, w == fl - 1, (f == nfr - 1) && (w == fl - 1)}));
        end
      end
    end
  endtask

  task automatic clear_caps();
    for (int k = 0; k < 3; k++) begin
      cap[k].delete();
      stray[k] = 0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((busy8 || busy16 || busy32) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({nm, " idle timeout"}, 64'(c < 3000), 64'd1);
  endtask

  // One run: start, then per-cycle wrusedw (random or a stall window) and an optional stop.
  task automatic run_stream(input int md, input int lim, input bit thr, input int stop_c,
                            input int st_lo, input int st_hi, input string nm);
    int c;
    bit fin, seen;
    clear_caps();
    gaps8 = 0;
    @(negedge clk);
    mode = 2'(md); frame_limit = 32'(lim); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0; fin = 1'b0; seen = 1'b0;
    while (c < 3000 && !fin) begin
      if (thr) wrusedw = rand_fill();
      else wrusedw = (c >= st_lo && c <= st_hi) ? 15'd16000 : 15'd0;
      stop = (c == stop_c);
      if (en8) seen = 1'b1;
      if (busy8 && !en8 && seen) gaps8++;
      if (!busy8 && !busy16 && !busy32) fin = 1'b1;
      @(negedge clk);
      c++;
    end
    stop = 1'b0; wrusedw = 15'd0;
    check({nm, " run timeout"}, 64'(fin), 64'd1);
  endtask

  task automatic compare_all(input int md, input int n8, input int n16, input int n32,
                             input string nm);
    compare_stream(0, 8,  FL8,  md, n8,  {nm, " w8"});
    compare_stream(1, 16, FL16, md, n16, {nm, " w16"});
    compare_stream(2, 32, FL32, md, n32, {nm, " w32"});
  endtask

  vec_t       tbl[34];
  logic [7:0] hb[8];
  int         md_r, lim_r;

  initial begin
    // Cycle-exact vectors for the 8-bit instance, ramp mode, two frames.
    hb = '{8'h1A, 8'hCF, 8'hFC, 8'h1D, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int j = 0; j < 34; j++) begin
      tbl[j]      = '0;
      tbl[j].busy = (j <= 32);
    end
    for (int k = 0; k < 32; k++) begin
      tbl[k+1].en   = 1'b1;
      tbl[k+1].data = ((k % 16) < 8) ? hb[k % 8] : 8'(k % 16);
      tbl[k+1].sof  = (k % 16) == 0;
      tbl[k+1].eof  = (k % 16) == 15;
      tbl[k+1].done = (k == 31);
    end
    tbl[24].data = 8'h01;

    RST = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; frame_limit = 32'd0; wrusedw = 15'd0;
    repeat (3) @(negedge clk);
    check("reset w8", 64'({d8, en8, sof8, eof8, done8, busy8, fc8}), 64'd0);
    check("reset w16", 64'({d16, en16, sof16, eof16, done16, busy16, fc16}), 64'd0);
    check("reset w32", {d32, fc32}, 64'd0);
    check("reset w32 flags", 64'({en32, sof32, eof32, done32, busy32}), 64'd0);
    RST = 1'b0;
    repeat (2) @(negedge clk);

    // Two ramp frames at full rate, checked cycle by cycle.
    clear_caps();
    @(negedge clk);
    mode = 2'd0; frame_limit = 32'd2; start = 1'b1;
    for (int j = 0; j < 34; j++) begin
      @(negedge clk);
      start   = 1'b0;
      wrusedw = tbl[j].wr;
      check($sformatf("vec %0d", j), 64'({d8, en8, sof8, eof8, done8, busy8}),
            64'({tbl[j].data, tbl[j].en, tbl[j].sof, tbl[j].eof, tbl[j].done, tbl[j].busy}));
    end
    check("vec frame_cnt", 64'(fc8), 64'd2);
    wait_idle("vec");
    compare_stream(1, 16, FL16, 0, 2, "vec w16");
    compare_stream(2, 32, FL32, 0, 2, "vec w32");

    // Five-cycle FIFO-full stall mid payload.
    run_stream(0, 1, 1'b0, -1, 10, 14, "stall");
    compare_all(0, 1, 1, 1, "stall");
    check("stall gaps", 64'(gaps8), 64'd5);

    // PRBS over three frames.
    run_stream(1, 3, 1'b0, -1, -1, -1, "prbs");
    compare_all(1, 3, 3, 3, "prbs");
    check("prbs gaps", 64'(gaps8), 64'd0);
    if (cap[2].size() >= 18) begin
      check("prbs w32 sync", 64'(cap[2][0].data), 64'h1ACFFC1D);
      check("prbs w32 first", 64'(cap[2][2].data), 64'h00000012);
      check("prbs w32 cnt2", 64'(cap[2][17].data), 64'd2);
    end else begin
      check("prbs w32 short", 64'(cap[2].size()), 64'd18);
    end

    // Unlimited run, stop arriving on word 60 (frame 4 of the 8-bit instance).
    run_stream(0, 0, 1'b0, 60, -1, -1, "stop");
    compare_all(0, 60 / FL8 + 1, 60 / FL16 + 1, 60 / FL32 + 1, "stop");
    check("stop frame_cnt", 64'(fc8), 64'd4);

    // Walking one and fill patterns.
    run_stream(3, 1, 1'b0, -1, -1, -1, "walk");
    compare_all(3, 1, 1, 1, "walk");
    if (cap[1].size() >= 21) begin
      check("walk w16 first", 64'(cap[1][4].data), 64'h0001);
      check("walk w16 top", 64'(cap[1][19].data), 64'h8000);
      check("walk w16 wrap", 64'(cap[1][20].data), 64'h0001);
    end else begin
      check("walk w16 short", 64'(cap[1].size()), 64'd24);
    end
    run_stream(2, 1, 1'b0, -1, -1, -1, "fill");
    compare_all(2, 1, 1, 1, "fill");

    // Random modes, limits and FIFO throttling.
    for (int r = 0; r < 8; r++) begin
      md_r  = $urandom_range(0, 3);
      lim_r = $urandom_range(1, 3);
      run_stream(md_r, lim_r, 1'b1, -1, -1, -1, $sformatf("rand%0d", r));
      compare_all(md_r, lim_r, lim_r, lim_r, $sformatf("rand%0d", r));
    end

    // Reset mid payload, then a fresh run starting from frame 0.
    @(negedge clk);
    mode = 2'd0; frame_limit = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre-abort busy", 64'({busy8, busy16, busy32}), 64'h7);
    RST = 1'b1;
    @(posedge clk);
    #1;
    check("abort w8", 64'({d8, en8, sof8, eof8, done8, busy8, fc8}), 64'd0);
    check("abort w16", 64'({d16, en16, sof16, eof16, done16, busy16, fc16}), 64'd0);
    check("abort w32", {d32, fc32}, 64'd0);
    check("abort w32 flags", 64'({en32, sof32, eof32, done32, busy32}), 64'd0);
    @(negedge clk);
    RST = 1'b0;
    run_stream(0, 1, 1'b0, -1, -1, -1, "restart");
    compare_all(0, 1, 1, 1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
